// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, memory-stage controller states and
// the load/store width encodings carried in func3.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    DONE
  } memctl_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Word-granular dcache port between the memory-stage controller (master)
// and the data cache (slave).
interface mem_access_ctrl_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  word_t dmemload;
  logic  dhit;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dmemload, dhit
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dmemload, dhit
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling: load field extract with sign/zero extension,
// and the sub-word store merge into a previously read cache word.
module mem_lane_align
  import cpu_types_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [1:0] addr_lo,
  input  word_t      word,
  input  word_t      data,
  output word_t      load_val,
  output word_t      store_word
);

  function automatic word_t ext_byte(input logic [7:0] b, input logic uns);
    logic signed [31:0] s;
    s = 32'(signed'(b));
    return uns ? {24'h0, b} : word_t'(s);
  endfunction

  function automatic word_t ext_half(input logic [15:0] h, input logic uns);
    logic signed [31:0] s;
    s = 32'(signed'(h));
    return uns ? {16'h0, h} : word_t'(s);
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        uns;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  // Halfwords are lane-selected by addr[1] only; addr[0] is ignored.
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  assign uns      = (func3 == F3_LBU) || (func3 == F3_LHU);

  always_comb begin
    load_val = word;
    case (func3)
      F3_LB, F3_LBU: load_val = ext_byte(byte_sel, uns);
      F3_LH, F3_LHU: load_val = ext_half(half_sel, uns);
      default:       load_val = word;
    endcase
  end

  always_comb begin
    store_word = data;
    case (func3)
      F3_SB: begin
        store_word = word;
        store_word[{addr_lo, 3'b000} +: 8] = data[7:0];
      end
      F3_SH: begin
        store_word = word;
        if (addr_lo[1]) store_word[31:16] = data[15:0];
        else            store_word[15:0]  = data[15:0];
      end
      default: store_word = data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns the latched EX/MEM request into dcache
// word transactions (RMW for sub-word stores) and holds the LR/SC reservation.
module mem_access_ctrl
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN_i,
  input  logic              dWEN_i,
  input  logic              atomic_i,
  input  logic [2:0]        func3_i,
  input  word_t             addr_i,
  input  word_t             wdata_i,
  mem_access_ctrl_if.master dbus,
  input  logic              inv_valid,
  input  word_t             inv_addr,
  output logic              done,
  output logic              stall,
  output word_t             rdata
);

  memctl_state_t state;
  logic          ren_q, wen_q;
  word_t         store_q, merge_q;
  logic          resv_valid;
  logic [29:0]   resv_addr;

  word_t load_val, merge_word;
  logic  req, word_match, snoop_hit, sc_ok, lr_hit, st_hit;
  logic  unused_inv_lo;

  mem_lane_align u_align (
    .func3      (func3_i),
    .addr_lo    (addr_i[1:0]),
    .word       (dbus.dmemload),
    .data       (wdata_i),
    .load_val   (load_val),
    .store_word (merge_word)
  );

  assign req           = dREN_i | dWEN_i;
  assign stall         = req & (state != DONE);
  assign word_match    = (resv_addr == addr_i[31:2]);
  assign snoop_hit     = inv_valid && (inv_addr[31:2] == resv_addr);
  assign sc_ok         = resv_valid && word_match && !snoop_hit;
  assign lr_hit        = (state == LOAD) && dbus.dhit && atomic_i;
  assign st_hit        = (state == STORE) && dbus.dhit;
  assign unused_inv_lo = ^inv_addr[1:0];

  assign dbus.dmemREN   = ren_q;
  assign dbus.dmemWEN   = wen_q;
  assign dbus.dmemaddr  = {addr_i[31:2], 2'b00};
  assign dbus.dmemstore = store_q;

  // Bus strobes, store word and done are registered alongside the next state
  // so they are a pure function of the current state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      store_q <= '0;
      merge_q <= '0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (dREN_i) begin
            state <= LOAD;
            ren_q <= 1'b1;
          end else if (atomic_i) begin
            if (sc_ok) begin
              state   <= STORE;
              wen_q   <= 1'b1;
              store_q <= wdata_i;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              rdata <= 32'd1;
            end
          end else if (func3_i == F3_SW) begin
            state   <= STORE;
            wen_q   <= 1'b1;
            store_q <= wdata_i;
          end else begin
            state <= RMW_RD;
            ren_q <= 1'b1;
          end
        end
        LOAD: if (dbus.dhit) begin
          state <= DONE;
          ren_q <= 1'b0;
          done  <= 1'b1;
          rdata <= load_val;
        end
        RMW_RD: if (dbus.dhit) begin
          state   <= STORE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b1;
          merge_q <= merge_word;
          store_q <= merge_word;
        end
        STORE: if (dbus.dhit) begin
          state <= DONE;
          wen_q <= 1'b0;
          done  <= 1'b1;
          if (atomic_i) rdata <= '0;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ren_q <= 1'b0;
          wen_q <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // A snoop landing on the same cycle as the LR completion kills the new reservation.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (lr_hit) begin
      resv_addr  <= addr_i[31:2];
      resv_valid <= !(inv_valid && (inv_addr[31:2] == addr_i[31:2]));
    end else if ((st_hit && word_match) || snoop_hit) begin
      resv_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, LR/SC and
// reset sequences, then random traffic against a word-level reference model.
module tb_mem_access_ctrl;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       dREN_i, dWEN_i, atomic_i, inv_valid;
  logic [2:0] func3_i;
  word_t      addr_i, wdata_i, inv_addr, rdata;
  logic       done, stall;

  int nerr = 0;
  int nchk = 0;

  word_t mem     [0:1023];
  word_t ref_mem [0:1023];

  always #5 CLK = ~CLK;

  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .dREN_i    (dREN_i),
    .dWEN_i    (dWEN_i),
    .atomic_i  (atomic_i),
    .func3_i   (func3_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .dbus      (bus),
    .inv_valid (inv_valid),
    .inv_addr  (inv_addr),
    .done      (done),
    .stall     (stall),
    .rdata     (rdata)
  );

  typedef struct {
    int         ren;
    int         wen;
    logic [2:0] f3;
    word_t      addr;
    word_t      data;
    word_t      init;
    int         lat;
    word_t      exp_rdata;
    int         exp_cyc;
    word_t      exp_mem;
  } vec_t;

  task automatic chk(input string nm, input word_t act, input word_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference load: pick the addressed field of the word, then extend it.
  function automatic word_t ref_load(input word_t w, input logic [2:0] f3, input logic [1:0] off);
    int sz;
    word_t m, v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (sz == 4) return w;
    if (sz == 2) off = {off[1], 1'b0};
    m = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (w >> (8 * off)) & m;
    if (!f3[2] && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  function automatic word_t ref_merge(input word_t old, input word_t d, input logic [2:0] f3, input logic [1:0] off);
    int sh;
    word_t m;
    if (f3 == F3_SW) return d;
    if (f3 == F3_SH) begin
      m  = 32'hFFFF;
      sh = off[1] ? 16 : 0;
    end else begin
      m  = 32'hFF;
      sh = 8 * off;
    end
    return (old & ~(m << sh)) | ((d & m) << sh);
  endfunction

  // Issue one request at a negedge and act as the dcache until done; returns
  // the done cycle (request cycle = 0), whether the bus was touched, stall sanity.
  task automatic do_req(input int ren, input int wen, input int atom, input logic [2:0] f3,
                        input word_t a, input word_t d, input int lat, input int snp, input word_t sa,
                        output int cyc, output logic touched, output logic stall_ok);
    int wc;
    wc = 0; cyc = -1; touched = 1'b0; stall_ok = 1'b1;
    dREN_i = (ren != 0); dWEN_i = (wen != 0); atomic_i = (atom != 0);
    func3_i = f3; addr_i = a; wdata_i = d;
    for (int c = 0; c < 60; c++) begin
      bus.dhit = 1'b0;
      inv_valid = 1'b0;
      #1;
      if (done) begin
        cyc = c;
        if (stall) stall_ok = 1'b0;
        break;
      end
      if (!stall) stall_ok = 1'b0;
      if (bus.dmemREN || bus.dmemWEN) begin
        touched = 1'b1;
        bus.dmemload = mem[bus.dmemaddr[11:2]];
        if (wc == lat - 1) begin
          wc = 0;
          bus.dhit = 1'b1;
          if (bus.dmemWEN) mem[bus.dmemaddr[11:2]] = bus.dmemstore;
          if (snp != 0 && bus.dmemREN) begin
            inv_valid = 1'b1;
            inv_addr  = sa;
          end
        end else begin
          wc++;
        end
      end
      @(negedge CLK);
    end
    if (cyc >= 0) @(negedge CLK);
    dREN_i = 1'b0; dWEN_i = 1'b0; atomic_i = 1'b0;
    bus.dhit = 1'b0; inv_valid = 1'b0;
  endtask

  task automatic op_check(input string nm, input int ren, input int wen, input int atom, input logic [2:0] f3,
                          input word_t a, input word_t d, input int lat, input int snp, input word_t sa,
                          input word_t exp_r, input int exp_c, output logic touched);
    int   cyc;
    logic sok;
    do_req(ren, wen, atom, f3, a, d, lat, snp, sa, cyc, touched, sok);
    chk({nm, "_cycles"}, word_t'(cyc), word_t'(exp_c));
    chk({nm, "_rdata"}, rdata, exp_r);
    chk({nm, "_stall"}, {31'b0, sok}, 32'd1);
  endtask

  task automatic pulse_snoop(input word_t a);
    inv_addr  = a;
    inv_valid = 1'b1;
    @(negedge CLK);
    inv_valid = 1'b0;
  endtask

  initial begin
    vec_t        tbl [11];
    logic        t, resv_v, snp;
    logic [29:0] resv_w;
    logic [9:0]  idx;
    logic [2:0]  f3;
    word_t       a, d, sa, exp_r, model_rdata;
    int          k, lat, exp_c, ren, wen, atom;

    tbl[0]  = '{1, 0, F3_LW,  32'h104, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 2, 32'hDEADBEEF};
    tbl[1]  = '{1, 0, F3_LB,  32'h107, 32'h0,        32'h80FF0000, 1, 32'hFFFFFF80, 2, 32'h80FF0000};
    tbl[2]  = '{1, 0, F3_LBU, 32'h107, 32'h0,        32'h80FF0000, 1, 32'h00000080, 2, 32'h80FF0000};
    tbl[3]  = '{1, 0, F3_LHU, 32'h106, 32'h0,        32'h80FF0000, 1, 32'h000080FF, 2, 32'h80FF0000};
    tbl[4]  = '{1, 0, F3_LH,  32'h106, 32'h0,        32'h80FF0000, 1, 32'hFFFF80FF, 2, 32'h80FF0000};
    tbl[5]  = '{0, 1, F3_SB,  32'h101, 32'h000000AB, 32'h11223344, 1, 32'hFFFF80FF, 3, 32'h1122AB44};
    tbl[6]  = '{0, 1, F3_SH,  32'h102, 32'h1234BEEF, 32'h11223344, 1, 32'hFFFF80FF, 3, 32'hBEEF3344};
    tbl[7]  = '{0, 1, F3_SW,  32'h108, 32'hCAFEF00D, 32'h00000000, 1, 32'hFFFF80FF, 2, 32'hCAFEF00D};
    tbl[8]  = '{1, 0, F3_LW,  32'h10C, 32'h0,        32'h01020304, 4, 32'h01020304, 5, 32'h01020304};
    tbl[9]  = '{0, 1, F3_SB,  32'h113, 32'h0000005A, 32'h00000000, 3, 32'h01020304, 7, 32'h5A000000};
    tbl[10] = '{1, 0, F3_LB,  32'h105, 32'h0,        32'h00007F00, 1, 32'h0000007F, 2, 32'h00007F00};

    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    nRST = 1'b0;
    dREN_i = 1'b0; dWEN_i = 1'b0; atomic_i = 1'b0; func3_i = '0;
    addr_i = '0; wdata_i = '0; inv_valid = 1'b0; inv_addr = '0;
    bus.dhit = 1'b0; bus.dmemload = '0;

    repeat (2) @(negedge CLK);
    #1;
    chk("rst_done",     {31'b0, done},         32'd0);
    chk("rst_stall",    {31'b0, stall},        32'd0);
    chk("rst_rdata",    rdata,                 32'd0);
    chk("rst_ren",      {31'b0, bus.dmemREN},  32'd0);
    chk("rst_wen",      {31'b0, bus.dmemWEN},  32'd0);
    chk("rst_store",    bus.dmemstore,         32'd0);
    chk("rst_addr",     bus.dmemaddr,          32'd0);
    chk("rst_state",    word_t'(dut.state),    word_t'(IDLE));
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 11; i++) begin
      mem[tbl[i].addr[11:2]] = tbl[i].init;
      op_check($sformatf("vec%0d", i), tbl[i].ren, tbl[i].wen, 0, tbl[i].f3, tbl[i].addr,
               tbl[i].data, tbl[i].lat, 0, 32'h0, tbl[i].exp_rdata, tbl[i].exp_cyc, t);
      chk($sformatf("vec%0d_mem", i), mem[tbl[i].addr[11:2]], tbl[i].exp_mem);
    end

    // LR/SC reservation sequences
    mem[10'h080] = 32'h77;
    op_check("lr1", 1, 0, 1, F3_LW, 32'h200, 32'h0, 1, 0, 32'h0, 32'h77, 2, t);
    op_check("sc_ok", 0, 1, 1, F3_SW, 32'h200, 32'h5, 1, 0, 32'h0, 32'h0, 2, t);
    chk("sc_ok_mem", mem[10'h080], 32'h5);
    op_check("sc_again", 0, 1, 1, F3_SW, 32'h200, 32'h9, 1, 0, 32'h0, 32'h1, 1, t);
    chk("sc_again_quiet", {31'b0, t}, 32'd0);
    chk("sc_again_mem", mem[10'h080], 32'h5);
    op_check("lr2", 1, 0, 1, F3_LW, 32'h200, 32'h0, 1, 0, 32'h0, 32'h5, 2, t);
    pulse_snoop(32'h202);
    op_check("sc_snooped", 0, 1, 1, F3_SW, 32'h200, 32'h9, 1, 0, 32'h0, 32'h1, 1, t);
    chk("sc_snooped_quiet", {31'b0, t}, 32'd0);
    op_check("lr3", 1, 0, 1, F3_LW, 32'h200, 32'h0, 2, 1, 32'h202, 32'h5, 3, t);
    op_check("sc_snoop_at_lr", 0, 1, 1, F3_SW, 32'h200, 32'h9, 1, 0, 32'h0, 32'h1, 1, t);
    chk("sc_snoop_at_lr_mem", mem[10'h080], 32'h5);
    op_check("lr4", 1, 0, 1, F3_LW, 32'h200, 32'h0, 1, 0, 32'h0, 32'h5, 2, t);
    pulse_snoop(32'h204);
    op_check("sc_other_snoop", 0, 1, 1, F3_SW, 32'h200, 32'h7, 1, 0, 32'h0, 32'h0, 2, t);
    chk("sc_other_snoop_mem", mem[10'h080], 32'h7);

    // Reset in the third cycle of a missing load, with a live reservation
    op_check("lr5", 1, 0, 1, F3_LW, 32'h200, 32'h0, 1, 0, 32'h0, 32'h7, 2, t);
    mem[10'h043] = 32'h01020304;
    dREN_i = 1'b1; func3_i = F3_LW; addr_i = 32'h10C;
    repeat (2) @(negedge CLK);
    #1;
    chk("miss_hold_c2", {31'b0, bus.dmemREN}, 32'd1);
    @(negedge CLK);
    #1;
    chk("miss_hold_c3", {31'b0, bus.dmemREN}, 32'd1);
    nRST = 1'b0;
    dREN_i = 1'b0; addr_i = '0;
    #1;
    chk("midrst_ren",   {31'b0, bus.dmemREN},   32'd0);
    chk("midrst_wen",   {31'b0, bus.dmemWEN},   32'd0);
    chk("midrst_done",  {31'b0, done},          32'd0);
    chk("midrst_rdata", rdata,                  32'd0);
    chk("midrst_store", bus.dmemstore,          32'd0);
    chk("midrst_addr",  bus.dmemaddr,           32'd0);
    chk("midrst_state", word_t'(dut.state),     word_t'(IDLE));
    chk("midrst_resv",  {31'b0, dut.resv_valid}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    op_check("sc_after_rst", 0, 1, 1, F3_SW, 32'h200, 32'h3, 1, 0, 32'h0, 32'h1, 1, t);
    chk("sc_after_rst_quiet", {31'b0, t}, 32'd0);

    // Random traffic against the reference model
    resv_v = 1'b0; resv_w = '0; model_rdata = 32'h1;
    for (int i = 0; i < 16; i++) begin
      mem[10'h0C0 + i] = $urandom;
      ref_mem[10'h0C0 + i] = mem[10'h0C0 + i];
    end
    for (int n = 0; n < 200; n++) begin
      k   = $urandom_range(0, 9);
      lat = $urandom_range(1, 3);
      d   = $urandom;
      a   = 32'h300 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      ren = (k <= 4 || k == 8) ? 1 : 0;
      wen = 1 - ren;
      atom = (k >= 8) ? 1 : 0;
      case (k)
        0: f3 = F3_LB;   1: f3 = F3_LH;   2: f3 = F3_LW;  3: f3 = F3_LBU;
        4: f3 = F3_LHU;  5: f3 = F3_SB;   6: f3 = F3_SH;  default: f3 = F3_SW;
      endcase
      if (f3 == F3_LW) a[1:0] = 2'b00;
      if (k == 9 && resv_v && $urandom_range(0, 2) != 0) a = {resv_w, 2'b00};
      idx = a[11:2];
      snp = 1'b0; sa = '0;
      exp_r = model_rdata;
      if (ren != 0) begin
        exp_r = ref_load(ref_mem[idx], f3, a[1:0]);
        exp_c = lat + 1;
        if (atom != 0) begin
          snp = ($urandom_range(0, 3) == 0);
          sa  = $urandom_range(0, 1) ? a : 32'h300 + ($urandom_range(0, 15) << 2);
          resv_w = a[31:2];
          resv_v = !(snp && sa[31:2] == a[31:2]);
        end
      end else if (atom != 0) begin
        if (resv_v && resv_w == a[31:2]) begin
          ref_mem[idx] = d; exp_r = 32'h0; exp_c = lat + 1; resv_v = 1'b0;
        end else begin
          exp_r = 32'h1; exp_c = 1;
        end
      end else begin
        ref_mem[idx] = ref_merge(ref_mem[idx], d, f3, a[1:0]);
        exp_c = (f3 == F3_SW) ? lat + 1 : 2 * lat + 1;
        if (a[31:2] == resv_w) resv_v = 1'b0;
      end
      model_rdata = exp_r;
      op_check($sformatf("rnd%0d", n), ren, wen, atom, f3, a, d, lat, {31'b0, snp}, sa, exp_r, exp_c, t);
      chk($sformatf("rnd%0d_mem", n), mem[idx], ref_mem[idx]);
      if (atom != 0 && wen != 0 && exp_c == 1) chk($sformatf("rnd%0d_quiet", n), {31'b0, t}, 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        sa = (resv_v && $urandom_range(0, 1) != 0) ? {resv_w, 2'($urandom_range(0, 3))}
                                                    : 32'h300 + $urandom_range(0, 63);
        if (sa[31:2] == resv_w) resv_v = 1'b0;
        pulse_snoop(sa);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller, directly downstream of the EX/MEM latch. It turns the latched memory request (load, store, LR.W, SC.W) into word-granular dcache transactions, with read-modify-write for sub-word stores. It formats load data and holds the LR/SC reservation. Its `done` pulse drives the latch's `dhit` input and the hazard unit's memory stall.

## Interface
- No parameters; address/data width fixed at 32 (`word_t`).
- CLK  in  1  clock
- nRST  in  1  reset nRST, asynchronous, active-low; clock CLK
- dREN_i  in  1  latched load request (EX/MEM `dREN_o`)
- dWEN_i  in  1  latched store request (EX/MEM `dWEN_o`)
- atomic_i  in  1  LR.W when with dREN_i, SC.W when with dWEN_i
- func3_i  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  32  byte address (EX/MEM `port_out_o`)
- wdata_i  in  32  store data, right-justified (EX/MEM `dmemstore_o`)
- dmemREN  out  1  dcache read request
- dmemWEN  out  1  dcache write request
- dmemaddr  out  32  word-aligned address, {addr_i[31:2],2'b00}
- dmemstore  out  32  full write word
- dmemload  in  32  dcache read word
- dhit  in  1  dcache completion for the current request
- inv_valid  in  1  coherence invalidate/write snoop
- inv_addr  in  32  snooped address; word compare only
- done  out  1  one-cycle completion pulse (to EX/MEM `dhit`)
- stall  out  1  memory stall to hazard unit
- rdata  out  32  formatted load result / SC status, held until next done

## Operation
- req = dREN_i | dWEN_i. Both high is illegal; the bench never drives it.
- FSM states: IDLE, LOAD, RMW_RD, STORE, DONE.
- IDLE, req high:
  - load or LR → LOAD
  - SW → STORE
  - SB/SH → RMW_RD
  - SC with resv_valid & resv_addr==addr_i[31:2] & no matching snoop this cycle → STORE
  - SC otherwise → DONE, rdata=1 (fail), no dcache access
- LOAD: dmemREN=1. On dhit, rdata ← extracted/extended field, → DONE.
  - B/BU lane = addr_i[1:0]; H/HU lane = addr_i[1] (addr_i[0] ignored); W ignores addr_i[1:0].
  - LR additionally sets resv_valid=1 and resv_addr=addr_i[31:2].
- RMW_RD: dmemREN=1. On dhit, merge_q ← dmemload with the byte/halfword lane replaced by wdata_i[7:0]/[15:0], → STORE.
- STORE: dmemWEN=1; dmemstore = merge_q for SB/SH, wdata_i for SW/SC. On dhit:
  - SC: rdata=0 (success); SW/SB/SH: rdata unchanged.
  - Any store whose word address equals resv_addr clears resv_valid.
  - → DONE.
- DONE: done=1, → IDLE. The EX/MEM latch clears dREN/dWEN on this edge, so there is no re-issue.
- stall = req & (state != DONE).
- Snoop: inv_valid & inv_addr[31:2]==resv_addr clears resv_valid. If this coincides with an LR dhit to the same word, the invalidate wins and the reservation stays clear.
- An in-flight access always completes. There is no flush input; the upstream latch holds the request while stalled.

## Timing
- Reset values: state=IDLE, dmemREN=0, dmemWEN=0, dmemaddr=0, dmemstore=0, done=0, rdata=0, merge_q=0, resv_valid=0, resv_addr=0.
- dmemREN, dmemWEN, dmemstore and done decode from state (Moore). dmemaddr is combinational from addr_i.
- Latency with a 1-cycle dhit:
  - LW/SW/SC-success: request seen in IDLE at cycle 0, access at cycle 1, done at cycle 2.
  - SB/SH: done at cycle 3.
  - SC-fail: done at cycle 1.
- A multi-cycle miss holds the access state and its outputs stable until dhit.
- Reset mid-access: immediate return to IDLE, all outputs 0, reservation lost.

## Structure
- cpu_types_pkg gains:
  - `memctl_state_t` enum (IDLE, LOAD, RMW_RD, STORE, DONE)
  - func3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, `F3_SB`, `F3_SH`, `F3_SW`
- Sub-module `mem_lane_align` (combinational): load extract/sign-extend, and store lane merge from func3, addr[1:0], word, data.

## Test plan
- LW addr 0x104 with dmemload 0xDEADBEEF → rdata 0xDEADBEEF; done at cycle 2; stall high cycles 0–1.
- LB addr 0x107, word 0x80FF0000 → rdata 0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x106 → 0x000080FF.
- SB addr 0x101, data 0xAB, old word 0x11223344 → RMW_RD then STORE with dmemstore 0x1122AB44; done at cycle 3.
- LR 0x200 then SC 0x200 data 5 → SC writes 5, rdata 0. A second SC to 0x200 → rdata 1, with dmemREN/dmemWEN never asserted.
- LR 0x200, inv_valid with inv_addr 0x202, then SC 0x200 → fail (rdata 1). Repeat with inv_addr asserted in the LR dhit cycle → same result.
- LW with dhit delayed 4 cycles, then nRST pulsed in the third LOAD cycle → outputs 0, state IDLE, resv_valid 0.
